// File: rtl/dmem_bus_ctrl_pkg.sv
// Shared core types for the MEM-stage data-memory path: access widths and
// the bus-controller state encoding.
package dmem_bus_ctrl_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } mem_width_t;

    // Stores share the width encoding of the signed loads.
    localparam mem_width_t SB = LB;
    localparam mem_width_t SH = LH;
    localparam mem_width_t SW = LW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Unused fun3 codes (011, 110, 111) fall through to word width.
    function automatic logic [1:0] size_code(input logic [2:0] fun3);
        case (fun3[1:0])
            2'd0:    size_code = SZ_BYTE;
            2'd1:    size_code = SZ_HALF;
            default: size_code = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bus_ctrl_align.sv
// Byte-lane logic for one access: lane selects, store-data replication,
// load extraction with sign/zero extension and the alignment check.
module lsu_align
    import dmem_bus_ctrl_pkg::*;
(
    input  logic [2:0]  fun3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    output logic [31:0] rdata_ext_o,
    output logic        misaligned_o
);

    logic [1:0]  sz;
    logic        is_byte;
    logic        is_half;
    logic        sign_ext;
    logic [31:0] shifted;

    assign sz       = size_code(fun3_i);
    assign is_byte  = (sz == SZ_BYTE);
    assign is_half  = (sz == SZ_HALF);
    assign sign_ext = ~fun3_i[2];
    assign shifted  = dat_i >> {addr_i, 3'b000};

    assign misaligned_o = (is_half & addr_i[0]) | ((sz == SZ_WORD) & (|addr_i));

    always_comb begin
        if (is_byte) begin
            sel_o = 4'b0001 << addr_i;
        end else if (is_half) begin
            sel_o = 4'b0011 << addr_i;
        end else begin
            sel_o = 4'hF;
        end
    end

    // Every lane carries the byte the slave will pick for its sel position.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign dat_o[8*gi +: 8] = is_byte ? wdata_i[7:0] :
                                  is_half ? wdata_i[8*(gi%2) +: 8] :
                                            wdata_i[8*gi +: 8];
    end

    always_comb begin
        if (is_byte) begin
            rdata_ext_o = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            rdata_ext_o = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        end else begin
            rdata_ext_o = shifted;
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// MEM-stage load/store to single-beat Wishbone-classic bridge with pipeline
// stall, misalignment and bus-fault reporting. Optional abort: DMEM_TIMEOUT_EN.
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_mem,
    input  logic              mem_write_mem,
    input  logic [2:0]        fun3_mem,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [31:0]       wdata_mem,
    output logic [31:0]       rdata_mem,
    output logic              stall_pipl,
    output logic              misaligned_mem,
    output logic              access_fault_mem,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [31:0]       dat_o,
    output logic [3:0]        sel_o,
    input  logic [31:0]       dat_i,
    input  logic              ack_i,
    input  logic              err_i
);

    dmem_state_t       state_q, state_d;
    logic              cyc_q;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       dat_q;
    logic [3:0]        sel_q;
    logic [2:0]        fun3_q;
    logic [1:0]        off_q;
    logic [31:0]       rdata_q;
    logic              fault_q;

    logic              req;
    logic              in_idle;
    logic              in_bus;
    logic              issue;
    logic              bus_end;
    logic              timeout_hit;
    logic [2:0]        align_fun3;
    logic [1:0]        align_off;
    logic [3:0]        align_sel;
    logic [31:0]       align_dat;
    logic [31:0]       align_rdata;
    logic              align_mis;

    assign req     = mem_read_mem | mem_write_mem;
    assign in_idle = (state_q == IDLE);
    assign in_bus  = (state_q == BUS);

    // Once the access is on the bus, extraction uses the captured width/offset.
    assign align_fun3 = in_idle ? fun3_mem      : fun3_q;
    assign align_off  = in_idle ? addr_mem[1:0] : off_q;

    lsu_align u_align (
        .fun3_i       (align_fun3),
        .addr_i       (align_off),
        .wdata_i      (wdata_mem),
        .dat_i        (dat_i),
        .sel_o        (align_sel),
        .dat_o        (align_dat),
        .rdata_ext_o  (align_rdata),
        .misaligned_o (align_mis)
    );

    assign issue   = in_idle & req & ~align_mis;
    assign bus_end = in_bus & (ack_i | err_i | timeout_hit);

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Idles at zero outside BUS, so every access starts counting afresh.
    assign cnt_d       = in_bus ? cnt_q + 1'b1 : '0;
    assign timeout_hit = in_bus & ~ack_i & ~err_i & (cnt_d == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUS;
            BUS:     if (bus_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            fun3_q  <= '0;
            off_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= 1'b0;
            if (issue) begin
                cyc_q  <= 1'b1;
                we_q   <= mem_write_mem;
                adr_q  <= {addr_mem[ADDR_W-1:2], 2'b00};
                dat_q  <= align_dat;
                sel_q  <= align_sel;
                fun3_q <= fun3_mem;
                off_q  <= addr_mem[1:0];
            end else if (bus_end) begin
                cyc_q   <= 1'b0;
                we_q    <= 1'b0;
                adr_q   <= '0;
                dat_q   <= '0;
                sel_q   <= '0;
                fault_q <= err_i | timeout_hit;
                // Faults and stores leave the latch cleared.
                rdata_q <= (ack_i & ~err_i & ~we_q) ? align_rdata : '0;
            end
        end
    end

    // Gated by reset so the freeze request falls with the bus strobes.
    assign stall_pipl       = ~reset & (issue | in_bus);
    assign misaligned_mem   = ~reset & in_idle & req & align_mis;
    assign access_fault_mem = fault_q;
    assign rdata_mem        = (state_q == DONE) ? rdata_q : '0;

    assign cyc_o = cyc_q;
    assign stb_o = cyc_q;
    assign we_o  = we_q;
    assign adr_o = adr_q;
    assign dat_o = dat_q;
    assign sel_o = sel_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: directed vector table, async-reset
// sequence, optional timeout abort, and randomized accesses against a model.
module tb_dmem_bus_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        clk;
    logic        reset;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [2:0]  fun3_mem;
    logic [31:0] addr_mem;
    logic [31:0] wdata_mem;
    logic [31:0] rdata_mem;
    logic        stall_pipl;
    logic        misaligned_mem;
    logic        access_fault_mem;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    int errors = 0;
    int checks = 0;

    dmem_bus_ctrl #(.ADDR_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_mem     (mem_read_mem),
        .mem_write_mem    (mem_write_mem),
        .fun3_mem         (fun3_mem),
        .addr_mem         (addr_mem),
        .wdata_mem        (wdata_mem),
        .rdata_mem        (rdata_mem),
        .stall_pipl       (stall_pipl),
        .misaligned_mem   (misaligned_mem),
        .access_fault_mem (access_fault_mem),
        .cyc_o            (cyc_o),
        .stb_o            (stb_o),
        .we_o             (we_o),
        .adr_o            (adr_o),
        .dat_o            (dat_o),
        .sel_o            (sel_o),
        .dat_i            (dat_i),
        .ack_i            (ack_i),
        .err_i            (err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: access of n bytes at byte offset k within the word.
    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = (1 << nbytes(f3)) - 1;
        return 4'(mask << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] m_dat(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(wd >> (8 * (i % n)));
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] d);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n = nbytes(f3);
        v = d >> (8 * int'(a[1:0]));
        if (n < 4) begin
            mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
            v = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    // waits < 0 means the slave never answers.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] bus_dat, input int waits,
                          input logic give_err, input logic ack_too,
                          input logic e_mis, input logic [3:0] e_sel, input logic [31:0] e_dat,
                          input logic [31:0] e_rdata, input logic e_fault, input int e_stall);
        int stall_cnt = 0;
        int bus_cyc = 0;
        bit done = 0;
        bit first = 0;
        mem_read_mem  = rd;
        mem_write_mem = wr;
        fun3_mem      = f3;
        addr_mem      = a;
        wdata_mem     = wd;
        if (e_mis) begin
            @(negedge clk);
            check({tag, " misaligned"}, 32'(misaligned_mem), 32'd1);
            check({tag, " mis_stall"},  32'(stall_pipl), 32'd0);
            check({tag, " mis_cyc"},    32'(cyc_o), 32'd0);
            check({tag, " mis_rdata"},  rdata_mem, 32'd0);
            @(posedge clk);
            #1;
        end else begin
            for (int c = 0; c < 200 && !done; c++) begin
                @(negedge clk);
                if (stall_pipl) stall_cnt++;
                if (cyc_o) begin
                    if (!first) begin
                        first = 1;
                        check({tag, " sel"}, 32'(sel_o), 32'(e_sel));
                        check({tag, " dat_o"}, dat_o, e_dat);
                        check({tag, " we"}, 32'(we_o), 32'(wr));
                        check({tag, " stb"}, 32'(stb_o), 32'd1);
                        check({tag, " adr"}, adr_o, {a[31:2], 2'b00});
                    end
                    if (waits >= 0 && bus_cyc == waits) begin
                        ack_i = ~give_err | ack_too;
                        err_i = give_err;
                        dat_i = bus_dat;
                    end
                    bus_cyc++;
                end else if (c > 0) begin
                    check({tag, " rdata"}, rdata_mem, e_rdata);
                    check({tag, " fault"}, 32'(access_fault_mem), 32'(e_fault));
                    check({tag, " done_stall"}, 32'(stall_pipl), 32'd0);
                    done = 1;
                end else begin
                    check({tag, " no_mis"}, 32'(misaligned_mem), 32'd0);
                end
                @(posedge clk);
                #1;
                ack_i = 1'b0;
                err_i = 1'b0;
            end
            check({tag, " completed"}, 32'(done), 32'd1);
            check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(e_stall));
        end
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        @(negedge clk);
        check({tag, " after_cyc"},   32'(cyc_o), 32'd0);
        check({tag, " after_stall"}, 32'(stall_pipl), 32'd0);
        check({tag, " after_mis"},   32'(misaligned_mem), 32'd0);
        check({tag, " after_fault"}, 32'(access_fault_mem), 32'd0);
        $display("txn %s rd=%0d wr=%0d f3=%0d addr=%h stall=%0d errors=%0d",
                 tag, rd, wr, f3, a, stall_cnt, errors);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] bus_dat;
        int          waits;
        logic        err;
        logic        ack_too;
        logic        e_mis;
        logic [3:0]  e_sel;
        logic [31:0] e_dat;
        logic [31:0] e_rdata;
        logic        e_fault;
        int          e_stall;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 1'b0,
                     1'b0, 4'hF, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h11,       32'h80123456, 0, 1'b0, 1'b0,
                     1'b0, 4'h8, 32'h11111111, 32'hFFFFFF80, 1'b0, 2};
        vecs[2]  = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h11,       32'h80123456, 0, 1'b0, 1'b0,
                     1'b0, 4'h8, 32'h11111111, 32'h00000080, 1'b0, 2};
        vecs[3]  = '{1'b0, 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,        3, 1'b0, 1'b0,
                     1'b0, 4'hC, 32'hABCDABCD, 32'h0,        1'b0, 5};
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        0, 1'b0, 1'b0,
                     1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 0};
        vecs[5]  = '{1'b1, 1'b0, 3'd2, 32'h104, 32'h0,        32'h55555555, 0, 1'b1, 1'b1,
                     1'b0, 4'hF, 32'h0,        32'h0,        1'b1, 2};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 32'h302, 32'h0,        32'h80017777, 1, 1'b0, 1'b0,
                     1'b0, 4'hC, 32'h0,        32'hFFFF8001, 1'b0, 3};
        vecs[7]  = '{1'b1, 1'b0, 3'd5, 32'h300, 32'h0,        32'h1234F00D, 0, 1'b0, 1'b0,
                     1'b0, 4'h3, 32'h0,        32'h0000F00D, 1'b0, 2};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 32'h001, 32'h000000A5, 32'h0,        1, 1'b0, 1'b0,
                     1'b0, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 3};
        vecs[9]  = '{1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h0,        0, 1'b0, 1'b0,
                     1'b0, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 2};
        vecs[10] = '{1'b0, 1'b1, 3'd1, 32'h203, 32'h0,        32'h0,        0, 1'b0, 1'b0,
                     1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 0};
        vecs[11] = '{1'b1, 1'b1, 3'd0, 32'h002, 32'h0000007E, 32'hFFFFFFFF, 0, 1'b0, 1'b0,
                     1'b0, 4'h4, 32'h7E7E7E7E, 32'h0,        1'b0, 2};
        vecs[12] = '{1'b1, 1'b0, 3'd3, 32'h010, 32'h0,        32'h89ABCDEF, 0, 1'b0, 1'b0,
                     1'b0, 4'hF, 32'h0,        32'h89ABCDEF, 1'b0, 2};
        vecs[13] = '{1'b1, 1'b0, 3'd6, 32'h012, 32'h0,        32'h0,        0, 1'b0, 1'b0,
                     1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 0};
        vecs[14] = '{1'b0, 1'b1, 3'd2, 32'h500, 32'h01020304, 32'h0,        2, 1'b1, 1'b0,
                     1'b0, 4'hF, 32'h01020304, 32'h0,        1'b1, 4};

        reset         = 1'b1;
        mem_read_mem  = 1'b0;
        mem_write_mem = 1'b0;
        fun3_mem      = 3'd0;
        addr_mem      = 32'h0;
        wdata_mem     = 32'h0;
        dat_i         = 32'h0;
        ack_i         = 1'b0;
        err_i         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst cyc",   32'(cyc_o), 32'd0);
        check("rst stb",   32'(stb_o), 32'd0);
        check("rst we",    32'(we_o), 32'd0);
        check("rst adr",   adr_o, 32'd0);
        check("rst dat",   dat_o, 32'd0);
        check("rst sel",   32'(sel_o), 32'd0);
        check("rst rdata", rdata_mem, 32'd0);
        check("rst stall", 32'(stall_pipl), 32'd0);
        check("rst mis",   32'(misaligned_mem), 32'd0);
        check("rst fault", 32'(access_fault_mem), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                   vecs[i].wd, vecs[i].bus_dat, vecs[i].waits, vecs[i].err, vecs[i].ack_too,
                   vecs[i].e_mis, vecs[i].e_sel, vecs[i].e_dat, vecs[i].e_rdata,
                   vecs[i].e_fault, vecs[i].e_stall);
        end

        // Reset during the second BUS cycle abandons the access at once.
        mem_read_mem = 1'b1;
        fun3_mem     = 3'd2;
        addr_mem     = 32'h600;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst cyc",   32'(cyc_o), 32'd0);
        check("midrst stb",   32'(stb_o), 32'd0);
        check("midrst stall", 32'(stall_pipl), 32'd0);
        mem_read_mem = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        $display("txn midrst addr=%h errors=%0d", 32'h600, errors);
        @(posedge clk);
        #1;
        access("postrst", 1'b1, 1'b0, 3'd2, 32'h604, 32'h0, 32'h0BADF00D, 0, 1'b0, 1'b0,
               1'b0, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, 2);

`ifdef DMEM_TIMEOUT_EN
        access("timeout", 1'b1, 1'b0, 3'd2, 32'h700, 32'h0, 32'h12345678, -1, 1'b0, 1'b0,
               1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1 + TB_TIMEOUT);
`endif

        for (int i = 0; i < 40; i++) begin
            logic        rd;
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] bd;
            int          w;
            logic        er;
            logic        at;
            logic        mis;
            logic [31:0] exp_rd;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = a[1:0] & 2'(~(nbytes(f3) - 1));
            wd = $urandom;
            bd = $urandom;
            w  = $urandom_range(0, 3);
            er = ($urandom_range(0, 7) == 0);
            at = 1'($urandom_range(0, 1));
            mis = m_mis(f3, a);
            exp_rd = (wr || er) ? 32'h0 : m_rdata(f3, a, bd);
            access($sformatf("rnd%0d", i), rd, wr, f3, a, wd, bd, w, er, at,
                   mis, m_sel(f3, a), m_dat(f3, wd), exp_rd, er, mis ? 0 : w + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_bus_ctrl.md
Name: dmem_bus_ctrl

Overview:
MEM-stage data-memory bus controller for the 5-stage RV32 core. It turns the MEM-stage load/store into a single-beat Wishbone-classic transaction: byte-lane select, store-data steering, and load extract with sign/zero extension. While the transaction is outstanding it drives stall_pipl into control_unit, which freezes every pipeline register. It also reports misaligned and bus-fault events to trap logic.

Parameters:
ADDR_W, 32, byte-address width of MEM-stage address and bus address
TIMEOUT, 255, max wait cycles for ack_i before abort; counter width is $clog2(TIMEOUT+1); only used with DMEM_TIMEOUT_EN

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
mem_read_mem  in  1  MEM-stage load
mem_write_mem  in  1  MEM-stage store
fun3_mem  in  3  load/store width: LB/LH/LW/LBU/LHU, SB/SH/SW
addr_mem  in  ADDR_W  effective address from EXE/MEM register
wdata_mem  in  32  store data, rs2 after forwarding
rdata_mem  out  32  aligned, extended load data to MEM/WB
stall_pipl  out  1  pipeline freeze request to control_unit
misaligned_mem  out  1  one-cycle pulse: misaligned access, no bus cycle issued
access_fault_mem  out  1  one-cycle pulse: err_i or timeout
cyc_o  out  1  bus cycle
stb_o  out  1  bus strobe
we_o  out  1  bus write enable
adr_o  out  ADDR_W  word-aligned address, low 2 bits forced 0
dat_o  out  32  lane-steered store data
sel_o  out  4  byte-lane enables
dat_i  in  32  bus read data
ack_i  in  1  bus acknowledge
err_i  in  1  bus error

Behaviour:
- Reset values: all outputs 0; state IDLE; read latch 0; timeout counter 0. Reset mid-transaction drops cyc_o/stb_o immediately and abandons the access. The slave must tolerate this.
- Request: req = mem_read_mem | mem_write_mem. If both are set, treat it as a store.
- Misalignment check: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- FSM states: IDLE, BUS, DONE.
- IDLE, req and aligned:
  - stall_pipl=1 combinationally in the same cycle.
  - Register cyc_o/stb_o/we_o/adr_o/dat_o/sel_o.
  - Go to BUS.
- IDLE, req and misaligned:
  - misaligned_mem=1 for this cycle; no bus cycle; stall_pipl=0; rdata_mem=0.
  - Stay in IDLE. Trap logic flushes the pipeline.
- BUS:
  - stall_pipl=1; bus outputs held stable.
  - On ack_i: latch the extracted load data (stores latch nothing) and go to DONE.
  - On err_i: go to DONE with access_fault_mem=1. err_i wins over a simultaneous ack_i.
  - cyc_o/stb_o drop on the transition edge.
- DONE:
  - stall_pipl=0; rdata_mem = latch.
  - The pipeline advances this cycle.
  - Unconditionally return to IDLE. This prevents re-issuing the same instruction, whose req is still visible this cycle.
- Latency: a zero-wait-state slave (ack_i in the first BUS cycle) gives 2 stall cycles per access. Each slave wait state adds 1.
- Byte lanes, k = addr[1:0]:
  - byte: sel=1<<k; dat_o = {4{wdata[7:0]}}.
  - half: sel=3<<k; dat_o = {2{wdata[15:0]}}.
  - word: sel=4'hF; dat_o = wdata.
  - The selected bits of dat_i are sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Invalid fun3 (3'b011, 3'b110, 3'b111 for loads): treat as word width.

Optional Feature:
DMEM_TIMEOUT_EN
- Defined: a counter runs in BUS and clears on entry to BUS. When it reaches TIMEOUT without ack_i/err_i, the access aborts: cyc_o/stb_o drop, access_fault_mem pulses, latch=0, go to DONE.
- Undefined: no counter; BUS waits indefinitely for ack_i/err_i.

Decomposition:
- Shared core package gets:
  - mem_width_t enum (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB/SH/SW reuse 0/1/2)
  - dmem_state_t enum {IDLE, BUS, DONE}
- One combinational sub-module, lsu_align:
  - inputs: fun3, addr[1:0], wdata, dat_i
  - outputs: sel, dat_o, rdata_ext, misaligned
- The FSM, latch and timeout counter stay in dmem_bus_ctrl.

Test Plan:
1. LW at 0x100, ack_i in the first BUS cycle, dat_i=0xDEADBEEF → stall_pipl high for exactly 2 cycles, sel_o=4'hF, rdata_mem=0xDEADBEEF in DONE, then IDLE.
2. LB at 0x103, dat_i=0x80xxxxxx → sel_o=4'b1000, rdata_mem=0xFFFFFF80. Same access as LBU → rdata_mem=0x00000080.
3. SH at 0x202, wdata=0x1234ABCD, 3 wait states → dat_o=0xABCDABCD, sel_o=4'b1100, we_o=1, stall_pipl high 5 cycles.
4. LW at 0x101 → misaligned_mem pulses 1 cycle, cyc_o stays 0, stall_pipl=0.
5. ack_i and err_i asserted together on an LW → access_fault_mem=1 and rdata_mem=0. With DMEM_TIMEOUT_EN and TIMEOUT=4 and no ack → abort after 4 BUS cycles with access_fault_mem.
6. reset asserted in the 2nd BUS cycle → cyc_o/stb_o/stall_pipl low asynchronously. After release, a new LW completes normally.
